// File: rtl/alu_mul.sv
// Iterative radix-2 shift-add multiplier for RV64M (MUL/MULH/MULHSU/MULHU/MULW).
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module alu_mul #(
    parameter int XLEN          = 64,
    parameter int SEL_MUL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          a,
    input  logic [XLEN-1:0]          b,
    input  logic [SEL_MUL_WIDTH-1:0] sig,
    input  logic                     stall,
    output logic [XLEN-1:0]          mul_c,
    output logic                     stall_this_alu_mul
);

    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [SEL_MUL_WIDTH-1:0] SEL_NONE   = SEL_MUL_WIDTH'(0);
    localparam logic [SEL_MUL_WIDTH-1:0] SEL_MUL    = SEL_MUL_WIDTH'(1);
    localparam logic [SEL_MUL_WIDTH-1:0] SEL_MULH   = SEL_MUL_WIDTH'(2);
    localparam logic [SEL_MUL_WIDTH-1:0] SEL_MULHSU = SEL_MUL_WIDTH'(3);
    localparam logic [SEL_MUL_WIDTH-1:0] SEL_MULHU  = SEL_MUL_WIDTH'(4);
    localparam logic [SEL_MUL_WIDTH-1:0] SEL_MULW   = SEL_MUL_WIDTH'(5);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [2*XLEN-1:0]        mc_q, mc_d;
    logic [XLEN-1:0]          mp_q, mp_d;
    logic [2*XLEN-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SEL_MUL_WIDTH-1:0] op_q, op_d;
    logic                     neg_q, neg_d;
    logic [XLEN-1:0]          mul_c_q, mul_c_d;

    // ---------------- operand preparation at issue ----------------
    logic            issue;
    logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
    logic            a_signed, b_signed, a_neg, b_neg;

    assign issue = (sig != SEL_NONE);

    always_comb begin
        op_a = a;
        op_b = b;
        if (sig == SEL_MULW) begin
            op_a = {{HALF{a[HALF-1]}}, a[HALF-1:0]};
            op_b = {{HALF{b[HALF-1]}}, b[HALF-1:0]};
        end
        a_signed = (sig != SEL_MULHU);
        b_signed = (sig != SEL_MULHU) && (sig != SEL_MULHSU);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        // Two's-complement negate; the most negative value maps onto itself as an unsigned magnitude.
        mag_a    = a_neg ? (~op_a + XLEN'(1)) : op_a;
        mag_b    = b_neg ? (~op_b + XLEN'(1)) : op_b;
    end

    // ---------------- iteration datapath ----------------
    logic [2*XLEN-1:0] acc_sum, prod;
    logic [XLEN-1:0]   mp_nxt;
    logic [CNT_W-1:0]  last_cnt;
    logic              last_iter;
    logic [XLEN-1:0]   res;

    assign acc_sum  = acc_q + (mp_q[0] ? mc_q : '0);
    assign mp_nxt   = mp_q >> 1;
    assign last_cnt = (op_q == SEL_MULW) ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == last_cnt) || (mp_nxt == '0);
`else
    assign last_iter = (cnt_q == last_cnt);
`endif

    // Sign is applied to the accumulator including this cycle's partial product.
    assign prod = neg_q ? (~acc_sum + (2*XLEN)'(1)) : acc_sum;

    always_comb begin
        case (op_q)
            SEL_MULH, SEL_MULHSU, SEL_MULHU: res = prod[2*XLEN-1:XLEN];
            SEL_MULW:                        res = {{HALF{prod[HALF-1]}}, prod[HALF-1:0]};
            default:                         res = prod[XLEN-1:0];
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue)     state_d = S_BUSY;
            S_BUSY:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (!stall)    state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Low in DONE so a still-present sig cannot relaunch the same instruction.
    always_comb begin
        stall_this_alu_mul = 1'b0;
        if (reset) begin
            stall_this_alu_mul = ((state_q == S_IDLE) && issue) || (state_q == S_BUSY);
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        mc_d    = mc_q;
        mp_d    = mp_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mul_c_d = mul_c_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    mc_d  = {{XLEN{1'b0}}, mag_a};
                    mp_d  = mag_b;
                    acc_d = '0;
                    cnt_d = '0;
                    op_d  = sig;
                    neg_d = a_neg ^ b_neg;
                end
            end
            S_BUSY: begin
                acc_d = acc_sum;
                mc_d  = mc_q << 1;
                mp_d  = mp_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) mul_c_d = res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_q    <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= SEL_NONE;
            neg_q   <= 1'b0;
            mul_c_q <= '0;
        end else begin
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mul_c_q <= mul_c_d;
        end
    end

    assign mul_c = mul_c_q;

endmodule

// File: doc/alu_mul.md
# alu_mul

Iterative radix-2 shift-add multiplier for the RV64M execute stage, the multiply counterpart of the multi-cycle divider. It sits beside `ALU_DIV` in EX, uses the same stall protocol and follows the same select convention. It covers MUL, MULH, MULHSU, MULHU and MULW. It latches its operands at issue and holds the pipeline through `stall_this_alu_mul` until the product is ready. It then holds the result until the downstream stall drops.

## Interface
- `XLEN`, 64: operand/result width; the accumulator is 2*XLEN.
- `SEL_MUL_WIDTH`, 3: width of `sig`. Encoding: 0 none, 1 MUL, 2 MULH, 3 MULHSU, 4 MULHU, 5 MULW.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `a`  in  XLEN  multiplicand (rs1).
- `b`  in  XLEN  multiplier (rs2).
- `sig`  in  SEL_MUL_WIDTH  operation select; nonzero requests an operation.
- `stall`  in  1  pipeline stall from other sources; result consumed when low.
- `mul_c`  out  XLEN  registered result.
- `stall_this_alu_mul`  out  1  combinational; high while a requested product is not yet ready.

## Operation
- FSM states and transitions:
  - IDLE: `sig` != 0 → BUSY at the next edge.
  - BUSY: final iteration → DONE.
  - DONE: `stall` low → IDLE; `stall` high → stay DONE.
- On leaving IDLE, latch `mc` = |a| and `mp` = |b|, the op, and `neg` = sign(a) XOR sign(b). Clear the 128-bit `acc` and set `cnt` = 0.
- Magnitude and sign rules per op:
  - MUL and MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU: no sign handling; `neg` = 0.
  - MULW: operands are `a[31:0]` and `b[31:0]`, sign-extended to 64 bits before the magnitude step.
- BUSY iteration:
  - If `mp[0]` is set, `acc += mc` (128-bit add).
  - Shift `mc` left by 1 and `mp` right by 1; increment `cnt`.
- Iteration count: 64 for the 64-bit ops and 32 for MULW. The last iteration is `cnt` = 63 or 31.
- On the final iteration edge:
  - Form the product as `neg` ? (~acc + 1) : acc, using the final-cycle accumulator value.
  - MUL: `mul_c` = low 64 bits.
  - MULH, MULHSU, MULHU: `mul_c` = high 64 bits.
  - MULW: `mul_c` = sign-extension of bits [31:0].
- `stall_this_alu_mul` = (state == IDLE && `sig` != 0) || state == BUSY. It is low in DONE, so the same instruction is never relaunched while stalled.
- `sig` and operand changes during BUSY or DONE are ignored.
- A zero operand gives 0 with full latency, unless early exit is enabled.
- Signed overflow wraps: MULH of 0x8000_0000_0000_0000 squared gives 0x4000_0000_0000_0000.

## Timing
- Reset (`reset` = 0, asynchronous): state IDLE, `cnt` 0, `acc` 0, `mul_c` 0. `stall_this_alu_mul` is forced 0 while reset is asserted.
- Reset mid-BUSY or in DONE aborts immediately; the operation is lost.
- Issue in cycle T (IDLE, `sig` != 0): `stall_this_alu_mul` is high in cycles T through T+64.
- `mul_c` is valid from T+65 (DONE). For MULW, stall is high in T through T+32 and the result is valid at T+33.
- DONE with `stall` high: `mul_c` is held; state exits to IDLE at the first edge with `stall` low.
- A new `sig` can launch in the cycle after returning to IDLE. Back-to-back ops therefore need at least one IDLE cycle.
- `mul_c` keeps its last value outside DONE; it is updated only on the final-iteration edge and on reset.

## Configuration
- `MUL_EARLY_EXIT_EN` defined: BUSY also finishes on any edge where the next `mp` is zero. The product is identical; latency is 1 + (index of the highest set bit of |b|) + 1 cycles, with a minimum of one BUSY cycle.
- `MUL_EARLY_EXIT_EN` undefined: fixed latency of 64 or 32 iterations as specified above. This is the default.

## Test plan
- MUL a=7, b=6 issued at T → `stall_this_alu_mul` high T..T+64, `mul_c` = 42 at T+65, state IDLE at T+66.
- a=b=0xFFFF_FFFF_FFFF_FFFF:
  - MULH → 0.
  - MULHU → 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU → 0xFFFF_FFFF_FFFF_FFFF.
  - MUL → 1.
- MULW a=0x0000_0000_7FFF_FFFF, b=2 → `mul_c` = 0xFFFF_FFFF_FFFF_FFFE at T+33, stall high 33 cycles.
- MUL 3×5 completes with `stall` held high 3 cycles in DONE → `mul_c` = 15 held, `stall_this_alu_mul` low, no relaunch. IDLE follows the first low-`stall` edge.
- Reset pulsed at BUSY `cnt` = 10 → immediate IDLE, `mul_c` = 0, stall low. After release, MUL 3×5 gives 15 at the normal latency.
- MULHU a=0x1234, b=1:
  - With `MUL_EARLY_EXIT_EN`: DONE at T+2, `mul_c` = 0.
  - Without it: DONE at T+65, same value.
